// File: rtl/udt_pkt_dispatch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// udt_pkt_dispatch_cnt
//   Wrapping event counter with synchronous clear. One instance per output
//   channel plus one for drops.
//   core_clk / core_rst : clock, async active-high reset
//   clr                 : synchronous clear, wins over a coincident inc
//   inc                 : count one event
//   cnt                 : current value, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module udt_pkt_dispatch_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// ---------------------------------------------------------------------------
// udt_pkt_dispatch
//   Classifies UDT packets from the first header word and routes each whole
//   packet to one of NUM_CH output channels (ch0 = data, ch1+k = control
//   type k). Unmapped or malformed packets are consumed and dropped.
//   Ports:
//     core_clk, core_rst      : clock, async active-high reset
//     in_t*                   : input stream (first byte in the MSBs)
//     out_tdata/tkeep/tlast   : shared registered output beat
//     out_tvalid / out_tready : one-hot per-channel handshake
//     cnt_clr                 : synchronous clear of all statistics
//     pkt_cnt                 : packets delivered, ch i at [i*CNT_W +: CNT_W]
//     drop_cnt                : packets dropped
//     busy                    : packet in flight or output register full
// ---------------------------------------------------------------------------
module udt_pkt_dispatch #(
    parameter int DATA_W = 64,
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    input  logic [DATA_W-1:0]       in_tdata,
    input  logic [DATA_W/8-1:0]     in_tkeep,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    output logic [DATA_W-1:0]       out_tdata,
    output logic [DATA_W/8-1:0]     out_tkeep,
    output logic                    out_tlast,
    output logic [NUM_CH-1:0]       out_tvalid,
    input  logic [NUM_CH-1:0]       out_tready,
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    busy
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int SEL_W  = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]        state;
    logic [SEL_W-1:0]  rsel;      // channel of the packet being routed
    logic [SEL_W-1:0]  osel;      // channel of the beat in the output register
    logic              ovalid;
    logic [DATA_W-1:0] odata;
    logic [KEEP_W-1:0] okeep;
    logic              olast;

    // ---------------- header classification (used in IDLE only) ----------
    logic              hdr_ctrl;
    logic [14:0]       hdr_type;
    logic [15:0]       type_p1;
    logic              malformed;
    logic              mapped;
    logic [SEL_W-1:0]  c_sel;

    assign hdr_ctrl  = in_tdata[DATA_W-1];
    assign hdr_type  = in_tdata[DATA_W-2 -: 15];
    assign type_p1   = {1'b0, hdr_type} + 16'd1;
    // The whole 32-bit header must be present in the first beat.
    assign malformed = (in_tkeep[KEEP_W-1 -: 4] != 4'hF);
    assign mapped    = !malformed && (!hdr_ctrl || (type_p1 < 16'(NUM_CH)));
    assign c_sel     = hdr_ctrl ? type_p1[SEL_W-1:0] : '0;

    // ---------------- handshakes ------------------------------------------
    logic accept;
    logic handoff;
    logic load;
    logic drop_inc;
    logic [SEL_W-1:0] load_sel;

    // Ready looks only at the register's own channel; DROP never stalls.
    assign in_tready = !core_rst &&
                       ((state == ST_DROP) || !ovalid || out_tready[osel]);
    assign accept    = in_tvalid && in_tready;
    assign handoff   = ovalid && out_tready[osel];
    assign load      = accept && (((state == ST_IDLE) && mapped) || (state == ST_ROUTE));
    assign load_sel  = (state == ST_IDLE) ? c_sel : rsel;
    assign drop_inc  = accept && (state == ST_IDLE) && !mapped;

    // ---------------- FSM + output register --------------------------------
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state  <= ST_IDLE;
            rsel   <= '0;
            osel   <= '0;
            ovalid <= 1'b0;
            odata  <= '0;
            okeep  <= '0;
            olast  <= 1'b0;
        end else begin
            // A load only happens when the register is empty or draining
            // this cycle, so it simply overwrites.
            if (load) begin
                ovalid <= 1'b1;
                osel   <= load_sel;
                odata  <= in_tdata;
                okeep  <= in_tkeep;
                olast  <= in_tlast;
            end else if (handoff) begin
                ovalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (mapped) begin
                            rsel <= c_sel;
                            if (!in_tlast)
                                state <= ST_ROUTE;
                        end else if (!in_tlast) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_ROUTE: begin
                    if (accept && in_tlast)
                        state <= ST_IDLE;
                end
                ST_DROP: begin
                    if (accept && in_tlast)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_tdata = odata;
    assign out_tkeep = okeep;
    assign out_tlast = olast;
    assign busy      = (state != ST_IDLE) || ovalid;

    // ---------------- per-channel valid + statistics ------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_done;
        assign out_tvalid[i] = ovalid && (osel == SEL_W'(i));
        assign ch_done       = out_tvalid[i] && out_tready[i] && olast;

        udt_pkt_dispatch_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
            .core_clk (core_clk),
            .core_rst (core_rst),
            .clr      (cnt_clr),
            .inc      (ch_done),
            .cnt      (pkt_cnt[i*CNT_W +: CNT_W])
        );
    end

    udt_pkt_dispatch_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .clr      (cnt_clr),
        .inc      (drop_inc),
        .cnt      (drop_cnt)
    );

endmodule

// File: tb/tb_udt_pkt_dispatch.sv
`timescale 1ns/1ps
module tb_udt_pkt_dispatch;

    localparam int DATA_W = 64;
    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;

    logic                    core_clk = 1'b0;
    logic                    core_rst = 1'b1;
    logic [DATA_W-1:0]       in_tdata = '0;
    logic [DATA_W/8-1:0]     in_tkeep = '0;
    logic                    in_tvalid = 1'b0;
    logic                    in_tready;
    logic                    in_tlast = 1'b0;
    logic [DATA_W-1:0]       out_tdata;
    logic [DATA_W/8-1:0]     out_tkeep;
    logic                    out_tlast;
    logic [NUM_CH-1:0]       out_tvalid;
    logic [NUM_CH-1:0]       out_tready = '1;
    logic                    cnt_clr = 1'b0;
    logic [NUM_CH*CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0]        drop_cnt;
    logic                    busy;

    udt_pkt_dispatch #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .cnt_clr    (cnt_clr),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        logic [7:0]        keep;
        logic              last;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [CNT_W-1:0] pcnt(input int ch);
        return pkt_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Scoreboard: every output handshake must match the oldest expected beat.
    always @(negedge core_clk) begin
        if (!core_rst && out_tvalid != '0) begin
            chk("onehot", 64'($onehot(out_tvalid)), 64'd1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (out_tvalid[i] && out_tready[i]) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_ch", 64'(i), 64'hFF);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("out_ch",   64'(i),     64'(e.ch));
                        chk("out_data", out_tdata,  e.data);
                        chk("out_keep", 64'(out_tkeep), 64'(e.keep));
                        chk("out_last", 64'(out_tlast), 64'(e.last));
                    end
                end
            end
        end
    end

    // Present one beat, wait (bounded) for acceptance; ch<0 means expect a drop.
    task automatic drive(input logic [DATA_W-1:0] d, input logic [7:0] k, input logic l,
                         input int ch, output int waited);
        beat_t b;
        waited    = 0;
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_tvalid = 1'b1;
        @(negedge core_clk);
        while (!in_tready && waited < 100) begin
            @(negedge core_clk);
            waited++;
        end
        chk("accept_in_time", 64'(waited < 100), 64'd1);
        if (ch >= 0) begin
            b.ch = ch; b.data = d; b.keep = k; b.last = l;
            sb.push_back(b);
        end
        @(posedge core_clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int n, input int ch);
        int w;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? {hdr, 32'($urandom())} : {32'($urandom()), 32'($urandom())};
            drive(d, 8'hFF, (i == n - 1), ch, w);
        end
    endtask

    initial begin
        int w;
        logic [DATA_W-1:0] b0;
        logic [DATA_W-1:0] b1;

        // ---- reset state ----
        #12;
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tready", 64'(in_tready),  64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_tdata",  out_tdata,       64'd0);
        chk("rst_drop",   64'(drop_cnt),   64'd0);
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        @(posedge core_clk); #1;

        // ---- 1: data packet, 3 beats, 1-cycle latency ----
        b0 = {32'h0000_0001, 32'h1111_2222};
        drive(b0, 8'hFF, 1'b0, 0, w);
        chk("t1_latency_vld", 64'(out_tvalid), 64'h01);
        chk("t1_busy", 64'(busy), 64'd1);
        drive({32'hA5A5_0001, 32'h0000_0002}, 8'hFF, 1'b0, 0, w);
        drive({32'hA5A5_0003, 32'h0000_0004}, 8'h3F, 1'b1, 0, w);
        repeat (3) @(posedge core_clk); #1;
        chk("t1_pkt_cnt0", 64'(pcnt(0)), 64'd1);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // ---- 2: ACK then NAK, ch3 backpressured for 5 cycles ----
        out_tready = 8'hF7;
        b0 = {32'h8002_0000, 32'hACAC_0000};
        b1 = {32'hACAC_0001, 32'hACAC_0002};
        drive(b0, 8'hFF, 1'b0, 3, w);
        in_tdata = b1; in_tkeep = 8'hFF; in_tlast = 1'b1; in_tvalid = 1'b1;
        repeat (5) begin
            @(negedge core_clk);
            chk("t2_in_tready", 64'(in_tready),  64'd0);
            chk("t2_hold_vld",  64'(out_tvalid), 64'h08);
            chk("t2_hold_data", out_tdata,       b0);
        end
        @(posedge core_clk); #1;
        out_tready = 8'hFF;
        drive(b1, 8'hFF, 1'b1, 3, w);
        send_pkt(32'h8003_0000, 2, 4);
        repeat (3) @(posedge core_clk); #1;
        chk("t2_pkt_cnt3", 64'(pcnt(3)), 64'd1);
        chk("t2_pkt_cnt4", 64'(pcnt(4)), 64'd1);

        // ---- 3: unmapped control type, 4 beats dropped ----
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? {32'hFFFF_0000, 32'h0} : {32'($urandom()), 32'($urandom())},
                  8'hFF, (i == 3), -1, w);
            chk("t3_drop_ready", 64'(w), 64'd0);
            chk("t3_no_vld", 64'(out_tvalid), 64'd0);
        end
        repeat (2) @(posedge core_clk); #1;
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);

        // ---- 4: malformed single beat, then a normal packet ----
        drive({32'h0000_0005, 32'h0}, 8'h70, 1'b1, -1, w);
        @(posedge core_clk); #1;
        chk("t4_no_vld", 64'(out_tvalid), 64'd0);
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
        send_pkt(32'h0000_0002, 2, 0);
        repeat (3) @(posedge core_clk); #1;
        chk("t4_pkt_cnt0", 64'(pcnt(0)), 64'd2);

        // ---- 5: counter wrap and clear priority ----
        for (int i = 0; i < 255; i++) send_pkt(32'h8000_0000, 1, 1);
        repeat (3) @(posedge core_clk); #1;
        chk("t5_pre_wrap", 64'(pcnt(1)), 64'd255);
        send_pkt(32'h8000_0000, 1, 1);
        repeat (3) @(posedge core_clk); #1;
        chk("t5_wrap", 64'(pcnt(1)), 64'd0);
        send_pkt(32'h8000_0000, 1, 1);
        repeat (3) @(posedge core_clk); #1;
        chk("t5_after_wrap", 64'(pcnt(1)), 64'd1);
        out_tready = 8'hFD;
        send_pkt(32'h8000_0000, 1, 1);
        chk("t5_held_vld", 64'(out_tvalid), 64'h02);
        out_tready = 8'hFF;
        cnt_clr = 1'b1;
        @(posedge core_clk); #1;
        cnt_clr = 1'b0;
        @(posedge core_clk); #1;
        chk("t5_clr_pkt1", 64'(pcnt(1)), 64'd0);
        chk("t5_clr_pkt0", 64'(pcnt(0)), 64'd0);
        chk("t5_clr_drop", 64'(drop_cnt), 64'd0);

        // ---- 6: reset mid-ROUTE, next beat is a new header ----
        drive({32'h0000_0003, 32'h6000_0000}, 8'hFF, 1'b0, 0, w);
        drive({32'h6000_0001, 32'h6000_0002}, 8'hFF, 1'b0, 0, w);
        chk("t6_busy", 64'(busy), 64'd1);
        in_tdata = {32'h8001_0000, 32'h6000_0003}; in_tkeep = 8'hFF;
        in_tlast = 1'b0; in_tvalid = 1'b1;
        core_rst = 1'b1;
        #1;
        chk("t6_rst_vld",   64'(out_tvalid), 64'd0);
        chk("t6_rst_ready", 64'(in_tready),  64'd0);
        chk("t6_rst_busy",  64'(busy),       64'd0);
        sb.delete();
        in_tvalid = 1'b0;
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        drive({32'h8001_0000, 32'h6000_0003}, 8'hFF, 1'b1, 2, w);
        repeat (3) @(posedge core_clk); #1;
        chk("t6_pkt_cnt2", 64'(pcnt(2)), 64'd1);
        chk("t6_pkt_cnt0", 64'(pcnt(0)), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        repeat (3) @(posedge core_clk); #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
